mod_updown_counter: RTL and testbench
=====================================

MOD_UPDOWN_COUNTER -- requirements
Module: mod_updown_counter

Interface
REQ-001 The block SHALL have parameter N, default 8, meaning counter width in bits (legal range 2..32).
REQ-002 The block SHALL have parameter MOD, default 256, meaning count modulus (legal range 2..2**N); count range is 0..MOD-1.
REQ-003 The block SHALL have parameter SAT, default 0, meaning 0 = wrap at the boundaries and 1 = saturate at the boundaries.
REQ-004 The port list SHALL be as follows:
- Clk   input  1  clock; all state changes on the rising edge.
- Clrn  input  1  asynchronous active-low reset.
- Clr   input  1  synchronous clear, active-high.
- Ld    input  1  synchronous load of D.
- D     input  N  load value.
- En    input  1  count enable.
- Up    input  1  direction: 1 = increment, 0 = decrement.
- Q     output N  current count.
- Tc    output 1  terminal count, combinational.
- Wrap  output 1  one-cycle registered pulse marking a wrap event.
- Ovf   output 1  sticky wrap/saturation-hit flag.

Function
REQ-005 Synchronous priority per rising Clk edge SHALL be Clr > Ld > En; with none active, Q SHALL hold.
REQ-006 Clr SHALL set Q=0, Wrap=0 and Ovf=0 on the next edge, regardless of Ld and En.
REQ-007 Ld SHALL set Q=D when D<=MOD-1, and Q=MOD-1 (clamped) when D>=MOD; a load SHALL NOT set Wrap or change Ovf.
REQ-008 En=1 with Up=1 SHALL advance Q to Q+1, except at Q=MOD-1:
- SAT=0: Q becomes 0.
- SAT=1: Q holds at MOD-1.
REQ-009 En=1 with Up=0 SHALL advance Q to Q-1, except at Q=0:
- SAT=0: Q becomes MOD-1.
- SAT=1: Q holds at 0.
REQ-010 Tc SHALL be 1 when En=1 and either (Up=1 and Q=MOD-1) or (Up=0 and Q=0); otherwise Tc SHALL be 0.
REQ-011 Wrap SHALL be 1 for exactly the one cycle following an edge at which SAT=0, Tc=1 and neither Clr nor Ld was active; otherwise Wrap SHALL be 0.
REQ-012 With SAT=1, Wrap SHALL remain 0.
REQ-013 Ovf SHALL be set on any edge at which Tc=1 and neither Clr nor Ld was active, in both SAT modes, and SHALL stay set until Clr or Clrn.
REQ-014 Incremental Q SHALL never leave the range 0..MOD-1.
REQ-015 When MOD=2**N, wrap SHALL coincide with natural N-bit rollover.
REQ-016 Back-to-back terminal events (MOD=2 with En held) SHALL produce Wrap=1 on every cycle.
REQ-017 A change of Up while En=1 SHALL take effect on the next edge, with no dead cycle.
REQ-018 Tc SHALL be the only combinational output; Q, Wrap and Ovf SHALL be registered.

Reset
REQ-019 Clrn=0 SHALL immediately, independent of Clk, force Q=0, Wrap=0 and Ovf=0.
REQ-020 While Clrn=0, all synchronous inputs SHALL be ignored.
REQ-021 Release of Clrn SHALL take effect at the first rising Clk edge after deassertion; that edge SHALL evaluate inputs normally.
REQ-022 Asserting Clrn mid-count or mid-Wrap-pulse SHALL clear state with no residual Wrap pulse after release.

Verification
REQ-023 The bench SHALL cover: N=4, MOD=10, SAT=0, Up=1, En=1 for 12 edges from reset -> Q = 1..9, 0, 1, 2; Wrap=1 only in the cycle after Q went 9->0; Ovf=1 from then on.
REQ-024 The bench SHALL cover: N=4, MOD=10, SAT=1, Ld with D=15 -> Q=9; then Up=1, En=1 for 3 edges -> Q stays 9, Tc=1, Wrap=0, Ovf=1.
REQ-025 The bench SHALL cover: N=4, MOD=10, SAT=0, Q=0, Up=0, En=1 -> next Q=9 and Wrap pulses once; then Clr=1 together with Ld=1 and En=1 -> Q=0, Ovf=0.
REQ-026 The bench SHALL cover: N=8, MOD=256, Ld D=0xFE, Up=1, En=1 for 3 edges -> Q = FF, 00, 01; Wrap after the 00 edge; Tc=1 only while Q=FF.
REQ-027 The bench SHALL cover: Clrn pulsed low between edges while Q=5 and Wrap=1 -> Q=0, Wrap=0 and Ovf=0 before the next edge; counting resumes from 0 after release.
REQ-028 The bench SHALL cover: MOD=2, SAT=0, En=1, Up toggling each cycle -> Q alternates 0/1, Tc=1 and Wrap=1 every cycle after the first.

Source files
------------

// File: rtl/mod_updown_counter.sv
// Modulo-MOD up/down counter with selectable wrap or saturate behaviour,
// synchronous clear/load, a combinational terminal-count flag and wrap/overflow flags.
module mod_updown_counter #(
  parameter int unsigned     N   = 8,
  parameter longint unsigned MOD = 256,
  parameter int              SAT = 0
) (
  input  logic         Clk,
  input  logic         Clrn,
  input  logic         Clr,
  input  logic         Ld,
  input  logic [N-1:0] D,
  input  logic         En,
  input  logic         Up,
  output logic [N-1:0] Q,
  output logic         Tc,
  output logic         Wrap,
  output logic         Ovf
);

  localparam logic [N-1:0] MAX = N'(MOD - 1);

  logic         at_max;
  logic         at_min;
  logic [N-1:0] load_val;
  logic [N-1:0] next_q;

  assign at_max   = (Q == MAX);
  assign at_min   = (Q == '0);
  assign Tc       = En & (Up ? at_max : at_min);
  assign load_val = (D > MAX) ? MAX : D;

  // At a boundary the counter either wraps to the opposite end or sticks there.
  always_comb begin
    next_q = Q;
    if (Up) begin
      if (at_max) next_q = (SAT != 0) ? MAX : '0;
      else        next_q = Q + N'(1);
    end else begin
      if (at_min) next_q = (SAT != 0) ? '0 : MAX;
      else        next_q = Q - N'(1);
    end
  end

  always_ff @(posedge Clk or negedge Clrn) begin
    if (!Clrn) begin
      Q    <= '0;
      Wrap <= 1'b0;
      Ovf  <= 1'b0;
    end else if (Clr) begin
      Q    <= '0;
      Wrap <= 1'b0;
      Ovf  <= 1'b0;
    end else if (Ld) begin
      Q    <= load_val;
      Wrap <= 1'b0;
    end else if (En) begin
      Q    <= next_q;
      Wrap <= Tc & (SAT == 0);
      if (Tc) Ovf <= 1'b1;
    end else begin
      Wrap <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mod_updown_counter.sv
// Self-checking bench: four counter configurations driven by shared inputs,
// compared every cycle against an arithmetic reference model plus directed scenarios.
module tb_mod_updown_counter;

  logic       clk = 1'b0;
  logic       clrn;
  logic       clr;
  logic       ld;
  logic [7:0] d;
  logic       en;
  logic       up;

  logic [3:0] q0;
  logic [3:0] q1;
  logic [7:0] q2;
  logic [1:0] q3;
  logic [3:0] tc;
  logic [3:0] wrap;
  logic [3:0] ovf;

  int numChecks = 0;
  int numErrors = 0;

  typedef struct {
    int n;
    int mod;
    int sat;
    int q;
    int w;
    int o;
  } mdl_t;

  mdl_t m[4];

  always #5 clk = ~clk;

  mod_updown_counter #(.N(4), .MOD(10), .SAT(0)) dutWrap10 (
    .Clk(clk), .Clrn(clrn), .Clr(clr), .Ld(ld), .D(d[3:0]), .En(en), .Up(up),
    .Q(q0), .Tc(tc[0]), .Wrap(wrap[0]), .Ovf(ovf[0]));

  mod_updown_counter #(.N(4), .MOD(10), .SAT(1)) dutSat10 (
    .Clk(clk), .Clrn(clrn), .Clr(clr), .Ld(ld), .D(d[3:0]), .En(en), .Up(up),
    .Q(q1), .Tc(tc[1]), .Wrap(wrap[1]), .Ovf(ovf[1]));

  mod_updown_counter #(.N(8), .MOD(256), .SAT(0)) dutFull8 (
    .Clk(clk), .Clrn(clrn), .Clr(clr), .Ld(ld), .D(d), .En(en), .Up(up),
    .Q(q2), .Tc(tc[2]), .Wrap(wrap[2]), .Ovf(ovf[2]));

  mod_updown_counter #(.N(2), .MOD(2), .SAT(0)) dutMod2 (
    .Clk(clk), .Clrn(clrn), .Clr(clr), .Ld(ld), .D(d[1:0]), .En(en), .Up(up),
    .Q(q3), .Tc(tc[3]), .Wrap(wrap[3]), .Ovf(ovf[3]));

  function automatic int getQ(input int i);
    case (i)
      0:       return int'(q0);
      1:       return int'(q1);
      2:       return int'(q2);
      default: return int'(q3);
    endcase
  endfunction

  task automatic checkOutput(input string tag, input int got, input int exp);
    numChecks++;
    if (got !== exp) begin
      numErrors++;
      $display("[TB] FAIL %s got=%0d expected=%0d at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int modelTc(input int i);
    if (!en) return 0;
    if (up)  return (m[i].q == m[i].mod - 1) ? 1 : 0;
    return (m[i].q == 0) ? 1 : 0;
  endfunction

  task automatic resetModel();
    for (int i = 0; i < 4; i++) begin
      m[i].q = 0;
      m[i].w = 0;
      m[i].o = 0;
    end
  endtask

  // One clock edge of the counter behaviour expressed as plain modular arithmetic.
  task automatic stepModel();
    for (int i = 0; i < 4; i++) begin
      int dv;
      int term;
      term = modelTc(i);
      if (clr) begin
        m[i].q = 0;
        m[i].w = 0;
        m[i].o = 0;
      end else if (ld) begin
        dv = int'(d) % (1 << m[i].n);
        m[i].q = (dv > m[i].mod - 1) ? m[i].mod - 1 : dv;
        m[i].w = 0;
      end else if (en) begin
        if (up) m[i].q = m[i].sat ? ((m[i].q + 1 > m[i].mod - 1) ? m[i].mod - 1 : m[i].q + 1)
                                  : (m[i].q + 1) % m[i].mod;
        else    m[i].q = m[i].sat ? ((m[i].q - 1 < 0) ? 0 : m[i].q - 1)
                                  : (m[i].q - 1 + m[i].mod) % m[i].mod;
        m[i].w = (term && !m[i].sat) ? 1 : 0;
        if (term) m[i].o = 1;
      end else begin
        m[i].w = 0;
      end
    end
  endtask

  task automatic checkRegs(input string tag);
    for (int i = 0; i < 4; i++) begin
      checkOutput($sformatf("%s.q%0d", tag, i), getQ(i), m[i].q);
      checkOutput($sformatf("%s.wrap%0d", tag, i), int'(wrap[i]), m[i].w);
      checkOutput($sformatf("%s.ovf%0d", tag, i), int'(ovf[i]), m[i].o);
    end
  endtask

  // Called at a falling edge: drive inputs, check Tc, clock once, check registers.
  task automatic applyStimulus(input bit c, input bit l, input logic [7:0] dv,
                               input bit e, input bit u);
    clr = c;
    ld  = l;
    d   = dv;
    en  = e;
    up  = u;
    #1;
    for (int i = 0; i < 4; i++)
      checkOutput($sformatf("tc%0d", i), int'(tc[i]), modelTc(i));
    @(posedge clk);
    stepModel();
    @(negedge clk);
    checkRegs("edge");
  endtask

  // Asserts Clrn just after a falling edge, holds it across edges with
  // random inputs, and releases it on a falling edge.
  task automatic pulseReset(input int holdEdges);
    #2;
    clrn = 1'b0;
    #1;
    resetModel();
    checkRegs("async");
    for (int k = 0; k < holdEdges; k++) begin
      clr = 1'($urandom_range(0, 1));
      ld  = 1'($urandom_range(0, 1));
      d   = 8'($urandom_range(0, 255));
      en  = 1'b1;
      up  = 1'($urandom_range(0, 1));
      @(posedge clk);
      @(negedge clk);
      checkRegs("inrst");
    end
    clrn = 1'b1;
    clr  = 1'b0;
    ld   = 1'b0;
    en   = 1'b0;
    up   = 1'b0;
    d    = '0;
  endtask

  initial begin
    m[0] = '{n: 4, mod: 10,  sat: 0, q: 0, w: 0, o: 0};
    m[1] = '{n: 4, mod: 10,  sat: 1, q: 0, w: 0, o: 0};
    m[2] = '{n: 8, mod: 256, sat: 0, q: 0, w: 0, o: 0};
    m[3] = '{n: 2, mod: 2,   sat: 0, q: 0, w: 0, o: 0};
    clrn = 1'b0;
    clr  = 1'b0;
    ld   = 1'b0;
    d    = '0;
    en   = 1'b0;
    up   = 1'b0;
    #1;
    checkRegs("reset");
    @(negedge clk);
    clrn = 1'b1;

    // Wrapping count-up through 9 -> 0 in the mod-10 counter.
    for (int k = 0; k < 12; k++) begin
      applyStimulus(0, 0, 8'd0, 1, 1);
      checkOutput("up10.q", int'(q0), (k + 1) % 10);
      checkOutput("up10.wrap", int'(wrap[0]), (k == 9) ? 1 : 0);
      checkOutput("up10.ovf", int'(ovf[0]), (k >= 9) ? 1 : 0);
    end

    // Saturating counter: oversized load clamps, then sticks at the top.
    applyStimulus(0, 1, 8'd15, 0, 0);
    checkOutput("sat.load", int'(q1), 9);
    for (int k = 0; k < 3; k++) begin
      applyStimulus(0, 0, 8'd0, 1, 1);
      checkOutput("sat.q", int'(q1), 9);
      checkOutput("sat.wrap", int'(wrap[1]), 0);
      checkOutput("sat.ovf", int'(ovf[1]), 1);
      checkOutput("sat.tc", int'(tc[1]), 1);
    end

    // Count-down wrap from 0, then clear wins over load and enable.
    applyStimulus(1, 0, 8'd0, 0, 0);
    checkOutput("dn.clr", int'(q0), 0);
    applyStimulus(0, 0, 8'd0, 1, 0);
    checkOutput("dn.q", int'(q0), 9);
    checkOutput("dn.wrap", int'(wrap[0]), 1);
    applyStimulus(0, 0, 8'd0, 0, 0);
    checkOutput("dn.wrapgone", int'(wrap[0]), 0);
    applyStimulus(1, 1, 8'd7, 1, 1);
    checkOutput("clrpri.q", int'(q0), 0);
    checkOutput("clrpri.ovf", int'(ovf[0]), 0);

    // Natural 8-bit rollover.
    applyStimulus(0, 1, 8'hFE, 0, 0);
    checkOutput("full.load", int'(q2), 8'hFE);
    for (int k = 0; k < 3; k++) begin
      applyStimulus(0, 0, 8'd0, 1, 1);
      checkOutput("full.q", int'(q2), (8'hFF + k) % 256);
      checkOutput("full.wrap", int'(wrap[2]), (k == 1) ? 1 : 0);
    end

    // Asynchronous reset mid-count and mid-wrap-pulse.
    applyStimulus(0, 1, 8'd5, 0, 0);
    checkOutput("ar.pre", int'(q0), 5);
    pulseReset(1);
    applyStimulus(0, 0, 8'd0, 1, 1);
    checkOutput("ar.resume", int'(q0), 1);
    applyStimulus(0, 1, 8'd0, 0, 0);
    applyStimulus(0, 0, 8'd0, 1, 0);
    checkOutput("ar.prewrap", int'(wrap[0]), 1);
    pulseReset(1);
    applyStimulus(0, 0, 8'd0, 0, 0);
    checkOutput("ar.nowrap", int'(wrap[0]), 0);
    checkOutput("ar.q", int'(q0), 0);

    // Mod-2 counter with direction toggling: a terminal event every edge.
    applyStimulus(1, 0, 8'd0, 0, 0);
    for (int k = 0; k < 6; k++) begin
      applyStimulus(0, 0, 8'd0, 1, k[0]);
      checkOutput("m2.q", int'(q3), (k % 2 == 0) ? 1 : 0);
      checkOutput("m2.wrap", int'(wrap[3]), 1);
    end

    // Randomized traffic across all configurations.
    for (int k = 0; k < 400; k++) begin
      if ($urandom_range(0, 49) == 0)
        pulseReset($urandom_range(1, 2));
      else
        applyStimulus($urandom_range(0, 19) == 0, $urandom_range(0, 9) == 0,
                      8'($urandom_range(0, 255)), $urandom_range(0, 3) != 0,
                      1'($urandom_range(0, 1)));
    end

    $display("Result: errors=%0d of %0d checks", numErrors, numChecks);
    $finish;
  end

endmodule
